sm_seg_scan: RTL

SM_SEG_SCAN -- requirements
Module: sm_seg_scan

---
 rtl/sm_seg_scan.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sm_seg_scan.sv
// Multiplexed 7-segment scanner: hex decode, leading-zero blanking, PWM brightness,
// and double-buffered data that only reaches the display at frame boundaries.
module sm_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1024,
  parameter int SEG_INV  = 1,
  parameter int AN_INV   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pend,
  output logic                  frame
);

  localparam int          PW   = $clog2(PRESCALE);
  localparam int          IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SLOT = PRESCALE / 16;
  localparam logic        SINV = (SEG_INV != 0);
  localparam logic        AINV = (AN_INV != 0);

  logic [PW-1:0]          r_pcnt;
  logic [IW-1:0]          r_idx;
  logic [4*DIGITS-1:0]    r_act_data;
  logic [DIGITS-1:0]      r_act_dp;
  logic [4*DIGITS-1:0]    r_pnd_data;
  logic [DIGITS-1:0]      r_pnd_dp;
  logic                   r_pend;
  logic                   r_frame;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [DIGITS-1:0]      r_an;

  logic                   w_tick;
  logic                   w_boundary;
  logic                   w_lit;
  logic                   w_blank;
  logic                   w_zero_run;
  logic [3:0]             w_nib;
  logic                   w_dp_sel;
  logic [6:0]             w_seg;
  logic                   w_dp;
  logic [DIGITS-1:0]      w_an;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_pcnt == PW'(PRESCALE - 1));
  assign w_boundary = w_tick && (r_idx == IW'(DIGITS - 1));
  assign w_lit      = (32'(r_pcnt) < ((32'(bright) + 32'd1) * SLOT));

  // Walk from the most significant digit down so the zero run covers nibbles i..DIGITS-1.
  always_comb begin
    w_zero_run = 1'b1;
    w_nib      = 4'h0;
    w_dp_sel   = 1'b0;
    w_blank    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_act_data[4*i +: 4] == 4'h0);
      if (i == int'(r_idx)) begin
        w_nib    = r_act_data[4*i +: 4];
        w_dp_sel = r_act_dp[i];
        w_blank  = (i != 0) && blank_lz && w_zero_run && !r_act_dp[i];
      end
    end
  end

  always_comb begin
    w_seg = 7'h00;
    w_dp  = 1'b0;
    w_an  = '0;
    if (w_lit && !w_blank) begin
      w_seg = hex7(w_nib);
      w_dp  = w_dp_sel;
      w_an  = DIGITS'(1) << r_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
      if (w_tick)
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  // A load landing on the boundary bypasses the pending buffer entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_pnd_data <= '0;
      r_pnd_dp   <= '0;
      r_pend     <= 1'b0;
      r_frame    <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (w_boundary) begin
        r_pend <= 1'b0;
        if (load) begin
          r_act_data <= data_in;
          r_act_dp   <= dp_in;
        end else if (r_pend) begin
          r_act_data <= r_pnd_data;
          r_act_dp   <= r_pnd_dp;
        end
      end else if (load) begin
        r_pnd_data <= data_in;
        r_pnd_dp   <= dp_in;
        r_pend     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= {7{SINV}};
      r_dp  <= SINV;
      r_an  <= {DIGITS{AINV}};
    end else begin
      r_seg <= w_seg ^ {7{SINV}};
      r_dp  <= w_dp ^ SINV;
      r_an  <= w_an ^ {DIGITS{AINV}};
    end
  end

  assign seg   = r_seg;
  assign dp    = r_dp;
  assign an    = r_an;
  assign pend  = r_pend;
  assign frame = r_frame;

endmodule
